// File: rtl/ibex_pkg.sv
// Shared fetch-path types and constants for the fetch request controller.
// Pure declarations: no timing or flow-control behaviour of its own.
package ibex_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_GNT_BR
  } fetch_req_state_e;

  localparam logic [31:0] FETCH_WORD_INCR = 32'd4;

  // Branch targets are halfword aligned; the bus only ever sees whole words.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// Instruction memory bus: req/gnt address phase, rvalid data phase, in order.
// Address must hold while req is high and gnt low; responses cannot be stalled.
interface ibex_fetch_req_ctrl_if;

  logic        instr_req_o;
  logic        instr_gnt_i;
  logic [31:0] instr_addr_o;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;

  modport master (
    output instr_req_o,
    output instr_addr_o,
    input  instr_gnt_i,
    input  instr_rvalid_i,
    input  instr_rdata_i,
    input  instr_err_i
  );

  modport slave (
    input  instr_req_o,
    input  instr_addr_o,
    output instr_gnt_i,
    output instr_rvalid_i,
    output instr_rdata_i,
    output instr_err_i
  );

endinterface

// File: rtl/ibex_fetch_outstanding.sv
// In-order queue of discard flags for granted requests; count/head update next cycle.
// No backpressure: the caller never pushes when full nor pops when empty.
module ibex_fetch_outstanding #(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             discard_all_i,
  input  logic                             push_discard_i,
  output logic [$clog2(NUM_REQS + 1)-1:0]  cnt_o,
  output logic                             head_discard_o
);

  localparam int unsigned CntW = $clog2(NUM_REQS + 1);

  logic [CntW-1:0]     cnt_q, cnt_d, wr_idx;
  logic [NUM_REQS-1:0] disc_q, disc_d;

  always_comb begin
    cnt_d  = cnt_q + CntW'(push_i) - CntW'(pop_i);
    wr_idx = cnt_q - CntW'(pop_i);
    disc_d = disc_q;
    // Flags beyond the valid count are don't-care, so marking all is safe.
    if (discard_all_i) begin
      disc_d = '1;
    end
    if (pop_i) begin
      disc_d = disc_d >> 1;
    end
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      if (push_i && (wr_idx == CntW'(i))) begin
        disc_d[i] = push_discard_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (ResetAll) begin : g_disc_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          disc_q <= '0;
        end else begin
          disc_q <= disc_d;
        end
      end
    end else begin : g_disc_noreset
      always_ff @(posedge clk_i) begin
        disc_q <= disc_d;
      end
    end
  endgenerate

  assign cnt_o          = cnt_q;
  assign head_discard_o = disc_q[0];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Fetch request controller: 0-cycle branch-to-request and response-to-FIFO paths.
// Requests are credit limited by outstanding count plus FIFO occupancy; a stalled request holds its address.
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [31:0]           addr_i,
  output logic                  busy_o,
  ibex_fetch_req_ctrl_if.master bus,
  output logic                  fifo_clear_o,
  output logic [31:0]           fifo_addr_o,
  input  logic [NUM_REQS-1:0]   fifo_busy_i,
  output logic                  fifo_valid_o,
  output logic [31:0]           fifo_rdata_o,
  output logic                  fifo_err_o
);

  localparam int unsigned CntW = $clog2(NUM_REQS + 1);

  fetch_req_state_e state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      br_addr_q, br_addr_d;
  logic [31:0]      branch_tgt, occ_cnt, instr_addr;
  logic [CntW-1:0]  out_cnt;
  logic             new_req_ok, instr_req, push, push_discard, head_discard;

  assign branch_tgt = word_align(addr_i);

  always_comb begin
    occ_cnt = '0;
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      occ_cnt = occ_cnt + 32'(fifo_busy_i[i]);
    end
  end

  // FIFO occupancy is irrelevant on a branch because the FIFO is flushed that cycle.
  assign new_req_ok = req_i && (32'(out_cnt) < NUM_REQS) &&
                      (branch_i || ((32'(out_cnt) + occ_cnt) < NUM_REQS));

  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    br_addr_d    = br_addr_q;
    instr_req    = 1'b0;
    instr_addr   = fetch_addr_q;
    push_discard = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_req  = new_req_ok;
        instr_addr = branch_i ? branch_tgt : fetch_addr_q;
        if (instr_req && bus.instr_gnt_i) begin
          fetch_addr_d = instr_addr + FETCH_WORD_INCR;
        end else begin
          fetch_addr_d = instr_addr;
          if (instr_req) begin
            state_d = WAIT_GNT;
          end
        end
      end
      WAIT_GNT: begin
        instr_req    = 1'b1;
        push_discard = branch_i;
        if (bus.instr_gnt_i) begin
          fetch_addr_d = branch_i ? branch_tgt : fetch_addr_q + FETCH_WORD_INCR;
          state_d      = IDLE;
        end else if (branch_i) begin
          br_addr_d = branch_tgt;
          state_d   = WAIT_GNT_BR;
        end
      end
      WAIT_GNT_BR: begin
        // The held request is stale; it completes only to keep the bus protocol legal.
        instr_req    = 1'b1;
        push_discard = 1'b1;
        if (bus.instr_gnt_i) begin
          fetch_addr_d = branch_i ? branch_tgt : br_addr_q;
          state_d      = IDLE;
        end else if (branch_i) begin
          br_addr_d = branch_tgt;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign push = instr_req & bus.instr_gnt_i;

  ibex_fetch_outstanding #(
    .NUM_REQS (NUM_REQS),
    .ResetAll (ResetAll)
  ) u_outstanding (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .push_i         (push),
    .pop_i          (bus.instr_rvalid_i),
    .discard_all_i  (branch_i),
    .push_discard_i (push_discard),
    .cnt_o          (out_cnt),
    .head_discard_o (head_discard)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  generate
    if (ResetAll) begin : g_addr_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          fetch_addr_q <= '0;
          br_addr_q    <= '0;
        end else begin
          fetch_addr_q <= fetch_addr_d;
          br_addr_q    <= br_addr_d;
        end
      end
    end else begin : g_addr_noreset
      always_ff @(posedge clk_i) begin
        fetch_addr_q <= fetch_addr_d;
        br_addr_q    <= br_addr_d;
      end
    end
  endgenerate

  assign bus.instr_req_o  = instr_req;
  assign bus.instr_addr_o = instr_addr;
  assign fifo_clear_o     = branch_i;
  assign fifo_addr_o      = addr_i;
  assign fifo_valid_o     = bus.instr_rvalid_i & ~head_discard & ~branch_i;
  assign fifo_rdata_o     = bus.instr_rdata_i;
  assign fifo_err_o       = bus.instr_err_i;
  assign busy_o           = instr_req | (out_cnt != '0);

  a_rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (!rst_ni) bus.instr_rvalid_i |-> (out_cnt != '0));

  a_stalled_addr_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (instr_req && !bus.instr_gnt_i) |=> (instr_req && (instr_addr == $past(instr_addr))));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// Self-checking bench: per-cycle vector table plus a memory model and response scoreboard.
module tb_ibex_fetch_req_ctrl;

  typedef struct {
    logic        req;
    logic        br;
    logic [31:0] baddr;
    logic        gnt;
    logic        rv;
    logic        err;
    logic [1:0]  fbusy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fv;
    logic        exp_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [1:0]  fifo_busy_i = '0;
  logic        busy_o, fifo_clear_o, fifo_valid_o, fifo_err_o;
  logic [31:0] fifo_addr_o, fifo_rdata_o;

  int total = 0;
  int bad = 0;
  logic [31:0] mem_q[$];
  logic [31:0] sb_q[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  ibex_fetch_req_ctrl_if bus ();

  ibex_fetch_req_ctrl #(
    .NUM_REQS (2),
    .ResetAll (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .branch_i     (branch_i),
    .addr_i       (addr_i),
    .busy_o       (busy_o),
    .bus          (bus),
    .fifo_clear_o (fifo_clear_o),
    .fifo_addr_o  (fifo_addr_o),
    .fifo_busy_i  (fifo_busy_i),
    .fifo_valid_o (fifo_valid_o),
    .fifo_rdata_o (fifo_rdata_o),
    .fifo_err_o   (fifo_err_o)
  );

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic req, br, input logic [31:0] baddr,
                              input logic gnt, rv, err, input logic [1:0] fb,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic efv, ebusy);
    vec_t v;
    v.req = req; v.br = br; v.baddr = baddr; v.gnt = gnt; v.rv = rv; v.err = err;
    v.fbusy = fb; v.exp_req = ereq; v.exp_addr = eaddr; v.exp_fv = efv; v.exp_busy = ebusy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1; checks at posedge+5 and returns at the next posedge+1.
  task automatic run(input vec_t v, input string tag);
    req_i                 = v.req;
    branch_i              = v.br;
    addr_i                = v.baddr;
    fifo_busy_i           = v.fbusy;
    bus.instr_gnt_i       = v.gnt;
    bus.instr_rvalid_i    = v.rv;
    bus.instr_err_i       = v.err;
    bus.instr_rdata_i     = '0;
    if (v.rv && (mem_q.size() > 0)) begin
      bus.instr_rdata_i = rdata_of(mem_q.pop_front());
    end
    #4;
    check({tag, " instr_req"}, 32'(bus.instr_req_o), 32'(v.exp_req));
    if (v.exp_req) begin
      check({tag, " instr_addr"}, bus.instr_addr_o, v.exp_addr);
    end
    check({tag, " fifo_valid"}, 32'(fifo_valid_o), 32'(v.exp_fv));
    check({tag, " busy"}, 32'(busy_o), 32'(v.exp_busy));
    check({tag, " fifo_clear"}, 32'(fifo_clear_o), 32'(v.br));
    check({tag, " fifo_addr"}, fifo_addr_o, v.baddr);
    check({tag, " fifo_err"}, 32'(fifo_err_o), 32'(v.err));
    if (v.rv) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL %s scoreboard: response with no expected entry", tag);
      end else begin
        check({tag, " fifo_rdata"}, fifo_rdata_o, sb_q.pop_front());
      end
    end
    if (bus.instr_req_o && v.gnt) mem_q.push_back(bus.instr_addr_o);
    if (v.exp_req && v.gnt) sb_q.push_back(rdata_of(v.exp_addr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_rdata_i  = '0;
    bus.instr_err_i    = 1'b0;

    //        req br baddr          gnt rv err fb     ereq eaddr           efv busy
    // Streaming: 0x0, 0x4, 0x8 with rvalid one cycle after grant.
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 2'b00, 1, 32'h4,        1, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 2'b00, 1, 32'h8,        1, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'hC,        0, 1));
    // Branch to 0x102 with the queue full: no request, both stale responses dropped.
    vecs.push_back(mk(1, 1, 32'h102,      0, 0, 0, 2'b00, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 2'b00, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 2'b00, 1, 32'h100,      0, 1));
    // Stall at 0x104, branch to 0x40 during the stall.
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 2'b00, 1, 32'h104,      1, 1));
    vecs.push_back(mk(0, 1, 32'h40,       0, 0, 0, 2'b00, 1, 32'h104,      0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 2'b00, 1, 32'h104,      0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'h104,      0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 2'b00, 1, 32'h40,       0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'h40,       0, 1));
    // Two branches during one stall: the later target wins.
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 2'b00, 1, 32'h44,       1, 1));
    vecs.push_back(mk(1, 1, 32'h40,       0, 0, 0, 2'b00, 1, 32'h44,       0, 1));
    vecs.push_back(mk(1, 1, 32'h80,       0, 0, 0, 2'b00, 1, 32'h44,       0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'h44,       0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 2'b00, 1, 32'h80,       0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 2'b00, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 2'b00, 0, 32'h0,        0, 0));
    // FIFO occupancy credit.
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b11, 0, 32'h0,        0, 0));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b01, 1, 32'h84,       0, 1));
    // Branch to 0x10 with a response in the same cycle, then an error response.
    vecs.push_back(mk(1, 1, 32'h10,       1, 1, 0, 2'b00, 1, 32'h10,       0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 1, 2'b00, 1, 32'h14,       1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 2'b00, 0, 32'h0,        1, 1));
    // Address wrap.
    vecs.push_back(mk(1, 1, 32'hFFFFFFFE, 1, 0, 0, 2'b00, 1, 32'hFFFFFFFC, 0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 0, 2'b00, 1, 32'h0,        1, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 0, 2'b00, 1, 32'h0,        0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 2'b00, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 2'b00, 0, 32'h0,        0, 0));
    // Branch arriving together with the grant of a stalled request.
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 0, 2'b00, 1, 32'h4,        0, 1));
    vecs.push_back(mk(1, 1, 32'h200,      1, 0, 0, 2'b00, 1, 32'h4,        0, 1));
    vecs.push_back(mk(1, 0, 32'h0,        1, 1, 0, 2'b00, 1, 32'h200,      0, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 0, 2'b00, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 0, 2'b00, 0, 32'h0,        0, 0));

    #12;
    check("reset instr_req", 32'(bus.instr_req_o), 32'h0);
    check("reset fifo_valid", 32'(fifo_valid_o), 32'h0);
    check("reset busy", 32'(busy_o), 32'h0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset with a response outstanding: everything is dropped, fetch restarts at 0.
    run(mk(1, 0, 32'h0, 1, 0, 0, 2'b00, 1, 32'h204, 0, 1), "pre_reset");
    rst_ni             = 1'b0;
    req_i              = 1'b0;
    branch_i           = 1'b0;
    bus.instr_gnt_i    = 1'b0;
    bus.instr_rvalid_i = 1'b0;
    bus.instr_err_i    = 1'b0;
    #4;
    check("midreset instr_req", 32'(bus.instr_req_o), 32'h0);
    check("midreset busy", 32'(busy_o), 32'h0);
    check("midreset fifo_valid", 32'(fifo_valid_o), 32'h0);
    mem_q.delete();
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    run(mk(1, 0, 32'h0, 1, 0, 0, 2'b00, 1, 32'h0, 0, 1), "post_reset0");
    run(mk(0, 0, 32'h0, 0, 1, 0, 2'b00, 0, 32'h0, 1, 1), "post_reset1");
    run(mk(0, 0, 32'h0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0), "post_reset2");
    check("scoreboard drained", 32'(sb_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
